// File: rtl/axi_sram_slave_pkg.sv
// rtl/axi_sram_slave_pkg.sv - shared response codes, FSM encodings and burst limits
package axi_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Longest burst honoured on either channel.
    localparam int MAX_BEATS = 16;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/axi_sram_array.sv
// rtl/axi_sram_array.sv - 2^ADDR_W x 32 word array, async read, byte-strobed sync write
// Ports:
//   clk        clock
//   rd_addr_i  word index for the combinational read port
//   rd_data_o  word at rd_addr_i (pre-edge contents)
//   wr_en_i    write enable
//   wr_addr_i  word index for the write port
//   wr_strb_i  byte enables, bit i -> wr_data_i[8i+7:8i]
//   wr_data_i  write data
module axi_sram_array #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [3:0]        wr_strb_i,
    input  logic [31:0]       wr_data_i
);

    logic [31:0] mem_q [0:(1 << ADDR_W)-1];

    // A read and a write to the same word in one cycle returns the old word.
    assign rd_data_o = mem_q[rd_addr_i];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb_i[b]) begin
                    mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI read/write responder serving bursts from an internal word array
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   arid/araddr/arlen/arvalid/arready read address channel (INCR, up to 16 beats)
//   rid/rdata/rresp/rlast/rvalid/rready read data channel
//   awid/awaddr/awlen/awvalid/awready write address channel
//   wdata/wstrb/wlast/wvalid/wready   write data channel
//   bid/bresp/bvalid/bready           write response channel
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int          ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h1fc0_0000,
    parameter int          RD_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int         HI_W      = 30 - ADDR_W;
    localparam logic [3:0] RD_LAT_M1 = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;
    localparam logic [4:0] MAX_CNT   = 5'(MAX_BEATS);

    function automatic logic in_range(input logic [HI_W-1:0] hi);
        return hi == BASE[31:ADDR_W+2];
    endfunction

    rd_state_e   rd_state_q, rd_state_d;
    logic [3:0]  rid_q, rid_d;
    logic [31:0] raddr_q, raddr_d;
    logic [4:0]  rcnt_q, rcnt_d;    // beats left, including the one on the bus
    logic [3:0]  rwait_q, rwait_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic        rd_load;
    logic [31:0] rd_load_addr;
    logic [31:0] mem_rdata;
    logic        rd_ok;

    wr_state_e   wr_state_q, wr_state_d;
    logic [3:0]  bid_q, bid_d;
    logic [31:0] waddr_q, waddr_d;
    logic [4:0]  wcnt_q, wcnt_d;
    logic        werr_q, werr_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        wr_en;
    logic        w_ok;
    logic        beat_err;

    // Byte offsets within a word carry no meaning here.
    logic unused_lsbs;
    assign unused_lsbs = ^{rd_load_addr[1:0], waddr_q[1:0]};

    axi_sram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk       (clk),
        .rd_addr_i (rd_load_addr[ADDR_W+1:2]),
        .rd_data_o (mem_rdata),
        .wr_en_i   (wr_en),
        .wr_addr_i (waddr_q[ADDR_W+1:2]),
        .wr_strb_i (wstrb),
        .wr_data_i (wdata)
    );

    // Address of the beat that may be loaded into rdata this cycle. Kept apart
    // from the FSM block so the array read does not feed back into itself.
    always_comb begin
        rd_load_addr = raddr_q;
        if (rd_state_q == R_IDLE) begin
            rd_load_addr = araddr;
        end else if (rd_state_q == R_DATA) begin
            rd_load_addr = raddr_q + 32'd4;
        end
    end

    assign rd_ok = in_range(rd_load_addr[31:ADDR_W+2]);
    assign w_ok  = in_range(waddr_q[31:ADDR_W+2]);

    always_comb begin
        rd_state_d = rd_state_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rcnt_d     = rcnt_q;
        rwait_d    = rwait_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        rd_load    = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    rid_d   = arid;
                    raddr_d = araddr;
                    rcnt_d  = (arlen > 8'd15) ? MAX_CNT : {1'b0, arlen[3:0]} + 5'd1;
                    rwait_d = 4'd0;
                    if (RD_LAT > 0) begin
                        rd_state_d = R_WAIT;
                    end else begin
                        rd_state_d = R_DATA;
                        rd_load    = 1'b1;
                        rlast_d    = (rcnt_d == 5'd1);
                    end
                end
            end
            R_WAIT: begin
                if (rwait_q == RD_LAT_M1) begin
                    rd_state_d = R_DATA;
                    rd_load    = 1'b1;
                    rlast_d    = (rcnt_q == 5'd1);
                end else begin
                    rwait_d = rwait_q + 4'd1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rcnt_q == 5'd1) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        // Next beat is loaded on the accepting edge: no bubble.
                        raddr_d = raddr_q + 32'd4;
                        rcnt_d  = rcnt_q - 5'd1;
                        rd_load = 1'b1;
                        rlast_d = (rcnt_q == 5'd2);
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        if (rd_load) begin
            rdata_d = rd_ok ? mem_rdata : 32'd0;
            rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rid_q      <= 4'd0;
            raddr_q    <= 32'd0;
            rcnt_q     <= 5'd0;
            rwait_q    <= 4'd0;
            rdata_q    <= 32'd0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rid_q      <= rid_d;
            raddr_q    <= raddr_d;
            rcnt_q     <= rcnt_d;
            rwait_q    <= rwait_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        bid_d      = bid_q;
        waddr_d    = waddr_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        bresp_d    = bresp_q;
        wr_en      = 1'b0;
        beat_err   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    bid_d      = awid;
                    waddr_d    = awaddr;
                    wcnt_d     = {1'b0, awlen} + 5'd1;
                    werr_d     = 1'b0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    wr_en    = w_ok;
                    // Burst length comes from awlen; wlast only grades the response.
                    beat_err = !w_ok || (wlast != (wcnt_q == 5'd1));
                    waddr_d  = waddr_q + 32'd4;
                    wcnt_d   = wcnt_q - 5'd1;
                    werr_d   = werr_q | beat_err;
                    if (wcnt_q == 5'd1) begin
                        wr_state_d = W_RESP;
                        bresp_d    = (werr_q | beat_err) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            bid_q      <= 4'd0;
            waddr_q    <= 32'd0;
            wcnt_q     <= 5'd0;
            werr_q     <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            bid_q      <= bid_d;
            waddr_q    <= waddr_d;
            wcnt_q     <= wcnt_d;
            werr_q     <= werr_d;
            bresp_q    <= bresp_d;
        end
    end

    assign arready = (rd_state_q == R_IDLE);
    assign rvalid  = (rd_state_q == R_DATA);
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

    assign awready = (wr_state_q == W_IDLE);
    assign wready  = (wr_state_q == W_DATA);
    assign bvalid  = (wr_state_q == W_RESP);
    assign bid     = bid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - scoreboard bench for axi_sram_slave against a word-array reference model
`timescale 1ns/1ps
module tb_axi_sram_slave;

    localparam int          ADDR_W = 12;
    localparam logic [31:0] BASE   = 32'h1fc0_0000;
    localparam int          DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    logic        rst3;
    logic [3:0]  l_arid;
    logic [31:0] l_araddr;
    logic [7:0]  l_arlen;
    logic        l_arvalid, l_arready;
    logic [3:0]  l_rid;
    logic [31:0] l_rdata;
    logic [1:0]  l_rresp;
    logic        l_rlast, l_rvalid, l_rready;
    logic        l_awready, l_wready, l_bvalid;
    logic [3:0]  l_bid;
    logic [1:0]  l_bresp;

    axi_sram_slave #(.ADDR_W(ADDR_W), .BASE(BASE), .RD_LAT(0)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axi_sram_slave #(.ADDR_W(ADDR_W), .BASE(BASE), .RD_LAT(3)) dut_lat (
        .clk(clk), .rst(rst3),
        .arid(l_arid), .araddr(l_araddr), .arlen(l_arlen), .arvalid(l_arvalid), .arready(l_arready),
        .rid(l_rid), .rdata(l_rdata), .rresp(l_rresp), .rlast(l_rlast), .rvalid(l_rvalid), .rready(l_rready),
        .awid(4'd0), .awaddr(32'd0), .awlen(4'd0), .awvalid(1'b0), .awready(l_awready),
        .wdata(32'd0), .wstrb(4'd0), .wlast(1'b0), .wvalid(1'b0), .wready(l_wready),
        .bid(l_bid), .bresp(l_bresp), .bvalid(l_bvalid), .bready(1'b0)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } b_exp_t;

    r_exp_t exp_r[$];
    b_exp_t exp_b[$];

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wbuf_d [16];
    logic [3:0]  wbuf_s [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: handshake did not happen within the cycle budget at %0t", name, $time);
    endtask

    function automatic bit ref_in_range(input logic [31:0] a);
        return (a >> (ADDR_W + 2)) == (BASE >> (ADDR_W + 2));
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a >> 2) % 32'(DEPTH));
    endfunction

    // Model: apply every in-range beat to ref_mem, predict bresp, then drive the bus.
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                             input int bad_beat, input int bdelay, input bit gaps);
        b_exp_t      e;
        bit          err;
        int          n, k;
        logic [31:0] a;
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a = addr + 32'(4 * i);
            if (ref_in_range(a)) begin
                k = ref_idx(a);
                for (int b = 0; b < 4; b++)
                    if (wbuf_s[i][b]) ref_mem[k][8*b +: 8] = wbuf_d[i][8*b +: 8];
            end else begin
                err = 1'b1;
            end
            if (i == bad_beat) err = 1'b1;
        end
        e.resp = err ? 2'b10 : 2'b00;
        e.id   = id;
        exp_b.push_back(e);

        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = 4'(len); awvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (awready) break;
            n++;
            if (n > 50) begin timeout_fail("aw_handshake"); break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0;

        for (int i = 0; i <= len; i++) begin
            if (gaps) begin
                wvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            wdata  = wbuf_d[i];
            wstrb  = wbuf_s[i];
            wlast  = ((i == len) != (i == bad_beat));
            wvalid = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (wready) break;
                n++;
                if (n > 50) begin timeout_fail("w_handshake"); break; end
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;

        bready = 1'b0;
        for (int c = 0; c < bdelay; c++) begin
            @(negedge clk);
            check("b_held_valid", 32'(bvalid), 32'd1);
            check("b_held_id", 32'(bid), 32'(id));
            @(posedge clk); #1;
        end
        bready = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bvalid) break;
            n++;
            if (n > 50) begin timeout_fail("b_handshake"); break; end
        end
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    // Model: expected beats are pushed before AR; the R monitor checks them.
    // mode 0: rready always high, 1: toggles every cycle, 2: random.
    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input int mode);
        r_exp_t      e;
        int          beats, got, n, lat, tog;
        logic [31:0] a;
        beats = (len > 8'd15) ? 16 : int'(len) + 1;
        for (int i = 0; i < beats; i++) begin
            a = addr + 32'(4 * i);
            e.data = ref_in_range(a) ? ref_mem[ref_idx(a)] : 32'd0;
            e.resp = ref_in_range(a) ? 2'b00 : 2'b10;
            e.last = (i == beats - 1);
            e.id   = id;
            exp_r.push_back(e);
        end

        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (arready) break;
            n++;
            if (n > 50) begin timeout_fail("ar_handshake"); break; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;

        lat = 1;
        forever begin
            @(negedge clk);
            if (rvalid) break;
            lat++;
            if (lat > 40) break;
        end
        check("r_first_latency", 32'(lat), 32'd1);

        got = 0; tog = 0; n = 0;
        while (got < beats && n < 200) begin
            @(posedge clk); #1;
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (tog % 2) == 1;
                default: rready = 1'($urandom_range(0, 1));
            endcase
            tog++;
            @(negedge clk);
            if (rvalid && rready) got++;
            n++;
        end
        if (got < beats) timeout_fail("r_beats");
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    // Monitors compare whatever the DUT presents against the head of the expected queue
    // every cycle valid is high, so a payload changing while stalled is caught too.
    always @(negedge clk) begin
        if (!rst && rvalid) begin
            if (exp_r.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL r_unexpected: rvalid with rdata %h but no beat expected", rdata);
            end else begin
                check("r_data", rdata, exp_r[0].data);
                check("r_resp", 32'(rresp), 32'(exp_r[0].resp));
                check("r_last", 32'(rlast), 32'(exp_r[0].last));
                check("r_id", 32'(rid), 32'(exp_r[0].id));
                if (rready) void'(exp_r.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bvalid) begin
            if (exp_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected: bvalid with bresp %0d but no response expected", bresp);
            end else begin
                check("b_resp", 32'(bresp), 32'(exp_b[0].resp));
                check("b_id", 32'(bid), 32'(exp_b[0].id));
                if (bready) void'(exp_b.pop_front());
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, start, len, bad;
        rst = 1'b1; rst3 = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        l_arid = '0; l_araddr = '0; l_arlen = '0; l_arvalid = 1'b0; l_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst3 = 1'b0;

        @(negedge clk);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resps", 32'({rresp, bresp}), 32'd0);
        check("rst_ids", 32'({rid, bid}), 32'd0);

        // Single-beat read of a known word.
        wbuf_d[0] = 32'hdeadbeef; wbuf_s[0] = 4'hf;
        axi_write(BASE + 32'h10, 0, 4'h3, -1, 0, 1'b0);
        axi_read(BASE + 32'h10, 8'd0, 4'h9, 0);

        // 16-beat write then 16-beat read with rready toggling.
        for (int i = 0; i < 16; i++) begin wbuf_d[i] = 32'(i); wbuf_s[i] = 4'hf; end
        axi_write(BASE, 15, 4'h1, -1, 0, 1'b0);
        axi_read(BASE, 8'd15, 4'h2, 1);

        // Partial strobes over all-ones.
        wbuf_d[0] = 32'hffffffff; wbuf_s[0] = 4'hf;
        axi_write(BASE + 32'h40, 0, 4'hb, -1, 0, 1'b0);
        wbuf_d[0] = 32'h11223344; wbuf_s[0] = 4'b0101;
        axi_write(BASE + 32'h40, 0, 4'hc, -1, 0, 1'b0);
        axi_read(BASE + 32'h40, 8'd0, 4'hd, 0);

        // Out-of-range read, and a burst straddling the top of the window.
        axi_read(BASE + (32'd4 << ADDR_W), 8'd1, 4'h4, 0);
        for (int i = 0; i < 4; i++) begin wbuf_d[i] = 32'ha5a50000 + 32'(i); wbuf_s[i] = 4'hf; end
        axi_write(BASE + (32'd4 << ADDR_W) - 32'd8, 3, 4'h5, -1, 0, 1'b1);
        axi_read(BASE + (32'd4 << ADDR_W) - 32'd8, 8'd3, 4'h8, 2);

        // wlast on beat 0 of a 2-beat burst.
        wbuf_d[0] = 32'h0badf00d; wbuf_d[1] = 32'h600dcafe; wbuf_s[0] = 4'hf; wbuf_s[1] = 4'hf;
        axi_write(BASE + 32'h80, 1, 4'h6, 0, 0, 1'b0);
        axi_read(BASE + 32'h80, 8'd1, 4'he, 0);

        // bready held low for 5 cycles.
        wbuf_d[0] = 32'hcafe0001; wbuf_s[0] = 4'hf;
        axi_write(BASE + 32'h90, 0, 4'ha, -1, 5, 1'b0);

        // arlen beyond 15 is clamped to 16 beats.
        axi_read(BASE, 8'd40, 4'h7, 0);

        // Fill words 0..255, then random traffic within them.
        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hf; end
            axi_write(BASE + 32'(blk * 64), 15, 4'(blk), -1, 0, 1'b0);
        end
        for (int it = 0; it < 30; it++) begin
            start = $urandom_range(0, 240);
            len   = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    wbuf_d[i] = $urandom;
                    wbuf_s[i] = 4'($urandom_range(0, 15));
                end
                bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
                axi_write(BASE + 32'(start * 4), len, 4'($urandom_range(0, 15)), bad,
                          $urandom_range(0, 3), 1'b1);
            end else begin
                axi_read(BASE + 32'(start * 4), 8'(len), 4'($urandom_range(0, 15)), 2);
            end
        end

        // RD_LAT=3 instance: latency, then reset while in the data phase.
        @(negedge clk);
        check("lat_rst_arready", 32'(l_arready), 32'd1);
        check("lat_rst_rvalid", 32'(l_rvalid), 32'd0);
        @(posedge clk); #1;
        l_arid = 4'h5; l_araddr = BASE + 32'h20; l_arlen = 8'd3; l_arvalid = 1'b1; l_rready = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (l_arready) break;
            n++;
            if (n > 50) begin timeout_fail("lat_ar_handshake"); break; end
        end
        @(posedge clk); #1;
        l_arvalid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (l_rvalid) break;
            lat++;
            if (lat > 40) break;
        end
        check("lat_first_rvalid", 32'(lat), 32'd4);
        check("lat_rid", 32'(l_rid), 32'h5);
        check("lat_rresp", 32'(l_rresp), 32'd0);
        check("lat_rlast_beat0", 32'(l_rlast), 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        @(negedge clk);
        check("midrst_rvalid", 32'(l_rvalid), 32'd0);
        check("midrst_arready", 32'(l_arready), 32'd1);
        check("midrst_rlast", 32'(l_rlast), 32'd0);
        check("midrst_rid", 32'(l_rid), 32'd0);
        check("midrst_rdata", l_rdata, 32'd0);

        n = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("queues_drained", 32'(exp_r.size() + exp_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
